// File: rtl/ctrl_seq.sv
// rtl/ctrl_seq.sv - six-T-state instruction sequencer with decoded control word
module ctrl_seq (
  input  logic       clk,
  input  logic       clr_n,
  input  logic       run,
  input  logic [3:0] opcode,
  output logic       pc_out,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mar_load,
  output logic       ram_out,
  output logic       ir_load,
  output logic       ir_out,
  output logic       a_load,
  output logic       a_out,
  output logic       b_load,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       out_load,
  output logic [2:0] tstate,
  output logic       halted
);

  typedef enum logic [2:0] {
    T1   = 3'd0,
    T2   = 3'd1,
    T3   = 3'd2,
    T4   = 3'd3,
    T5   = 3'd4,
    T6   = 3'd5,
    HALT = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0011;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  state_t r_state;

  // HALT is left only through clr_n; run=0 freezes the T-state.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= T1;
    end else if (run) begin
      case (r_state)
        T1:   r_state <= T2;
        T2:   r_state <= T3;
        T3:   r_state <= T4;
        T4: begin
          if (opcode == OP_HLT) r_state <= HALT;
          else                  r_state <= T5;
        end
        T5:   r_state <= T6;
        T6:   r_state <= T1;
        HALT: r_state <= HALT;
        default: r_state <= T1;
      endcase
    end
  end

  assign tstate = r_state;
  assign halted = (r_state == HALT);

  // Control word is decoded combinationally; the datapath captures it on the edge closing the state.
  always_comb begin
    pc_out   = 1'b0;
    pc_inc   = 1'b0;
    pc_load  = 1'b0;
    mar_load = 1'b0;
    ram_out  = 1'b0;
    ir_load  = 1'b0;
    ir_out   = 1'b0;
    a_load   = 1'b0;
    a_out    = 1'b0;
    b_load   = 1'b0;
    alu_out  = 1'b0;
    alu_sub  = 1'b0;
    out_load = 1'b0;
    if (run) begin
      case (r_state)
        T1: begin
          pc_out   = 1'b1;
          mar_load = 1'b1;
        end
        T2: pc_inc = 1'b1;
        T3: begin
          ram_out = 1'b1;
          ir_load = 1'b1;
        end
        T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              ir_out   = 1'b1;
              mar_load = 1'b1;
            end
            OP_JMP: begin
              ir_out  = 1'b1;
              pc_load = 1'b1;
            end
            OP_OUT: begin
              a_out    = 1'b1;
              out_load = 1'b1;
            end
            default: ;
          endcase
        end
        T5: begin
          case (opcode)
            OP_LDA: begin
              ram_out = 1'b1;
              a_load  = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              ram_out = 1'b1;
              b_load  = 1'b1;
              alu_sub = (opcode == OP_SUB);
            end
            default: ;
          endcase
        end
        T6: begin
          if (opcode == OP_ADD || opcode == OP_SUB) begin
            alu_out = 1'b1;
            a_load  = 1'b1;
            alu_sub = (opcode == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
